// File: rtl/nf_pwm_dt.sv
// nf_pwm_dt: dead-time insertion turning one raw PWM signal into a complementary gate pair.
// Optional fault input and latched STATUS bit3 are enabled by defining NF_PWM_DT_FAULT_EN.
module nf_pwm_dt #(
  parameter int dt_width = 8
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic [31:0] addr,
  input  logic        we,
  input  logic [31:0] wd,
  output logic [31:0] rd,
  input  logic        pwm_in,
`ifdef NF_PWM_DT_FAULT_EN
  input  logic        pwm_fault,
`endif
  output logic        pwm_h,
  output logic        pwm_l
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    DEAD = 2'd1,
    HI   = 2'd2,
    LO   = 2'd3
  } state_t;

  state_t                state;
  logic                  en;
  logic [dt_width-1:0]   dt;
  logic [dt_width-1:0]   cnt;
  logic                  target;
  logic                  pwm_meta;
  logic                  pwm_s;
  logic                  fault_s;
  logic                  fault_lat;
  logic                  stop;
  logic                  unused_bits;

  assign unused_bits = ^{addr[31:4], addr[1:0], wd};

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      pwm_meta <= 1'b0;
      pwm_s    <= 1'b0;
    end else begin
      pwm_meta <= pwm_in;
      pwm_s    <= pwm_meta;
    end
  end

`ifdef NF_PWM_DT_FAULT_EN
  logic fault_meta;

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      fault_meta <= 1'b0;
      fault_s    <= 1'b0;
    end else begin
      fault_meta <= pwm_fault;
      fault_s    <= fault_meta;
    end
  end

  // A live fault outranks a simultaneous W1C so the latch cannot be cleared under fault.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      fault_lat <= 1'b0;
    end else if (fault_s) begin
      fault_lat <= 1'b1;
    end else if (we && addr[3:2] == 2'd2 && wd[3]) begin
      fault_lat <= 1'b0;
    end
  end
`else
  assign fault_s   = 1'b0;
  assign fault_lat = 1'b0;
`endif

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      en <= 1'b0;
      dt <= '0;
    end else if (we) begin
      case (addr[3:2])
        2'd0:    en <= wd[0];
        2'd1:    dt <= wd[dt_width-1:0];
        default: ;
      endcase
    end
  end

  always_comb begin
    rd = '0;
    case (addr[3:2])
      2'd0: rd[0] = en;
      2'd1: rd[dt_width-1:0] = dt;
      2'd2: begin
        rd[1:0] = state;
        rd[3]   = fault_lat;
      end
      default: ;
    endcase
  end

  assign stop = !en || fault_s || fault_lat;

  // Gate outputs are written alongside each transition so they always match the new state.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state  <= IDLE;
      target <= 1'b0;
      cnt    <= '0;
      pwm_h  <= 1'b0;
      pwm_l  <= 1'b0;
    end else if (stop) begin
      state <= IDLE;
      pwm_h <= 1'b0;
      pwm_l <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          state  <= DEAD;
          target <= pwm_s;
          cnt    <= dt;
          pwm_h  <= 1'b0;
          pwm_l  <= 1'b0;
        end
        DEAD: begin
          if (pwm_s != target) begin
            target <= pwm_s;
            cnt    <= dt;
          end else if (cnt == '0) begin
            if (target) begin
              state <= HI;
              pwm_h <= 1'b1;
            end else begin
              state <= LO;
              pwm_l <= 1'b1;
            end
          end else begin
            cnt <= cnt - dt_width'(1);
          end
        end
        HI: begin
          if (!pwm_s) begin
            state  <= DEAD;
            target <= 1'b0;
            cnt    <= dt;
            pwm_h  <= 1'b0;
          end
        end
        LO: begin
          if (pwm_s) begin
            state  <= DEAD;
            target <= 1'b1;
            cnt    <= dt;
            pwm_l  <= 1'b0;
          end
        end
        default: begin
          state <= IDLE;
          pwm_h <= 1'b0;
          pwm_l <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_nf_pwm_dt.sv
// Self-checking bench for nf_pwm_dt: register vector table plus timed dead-band sequences.
// The fault sequence is compiled in only when NF_PWM_DT_FAULT_EN is defined.
module tb_nf_pwm_dt;

  logic        clk;
  logic        resetn;
  logic [31:0] addr;
  logic        we;
  logic [31:0] wd;
  logic [31:0] rd;
  logic        pwm_in;
  logic        pwm_fault;
  logic        pwm_h;
  logic        pwm_l;

  typedef struct {
    string       name;
    logic [31:0] addr;
    logic        we;
    logic [31:0] wd;
    logic [31:0] exp_rd;
  } reg_vec_t;

  typedef struct {
    string       name;
    logic [31:0] value;
  } exp_t;

  reg_vec_t vecs[8];
  exp_t     sb_q[$];
  int       pass_cnt = 0;
  int       total_cnt = 0;
  int       overlap_cnt = 0;
  int       h_high_cnt = 0;

  nf_pwm_dt #(.dt_width(8)) dut (
    .clk      (clk),
    .resetn   (resetn),
    .addr     (addr),
    .we       (we),
    .wd       (wd),
    .rd       (rd),
    .pwm_in   (pwm_in),
`ifdef NF_PWM_DT_FAULT_EN
    .pwm_fault(pwm_fault),
`endif
    .pwm_h    (pwm_h),
    .pwm_l    (pwm_l)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (pwm_h && pwm_l) overlap_cnt++;
    if (pwm_h) h_high_cnt++;
  end

  task automatic expectPush(input string n, input logic [31:0] v);
    exp_t e;
    e.name  = n;
    e.value = v;
    sb_q.push_back(e);
  endtask

  task automatic checkOutput(input logic [31:0] actual);
    exp_t e;
    total_cnt++;
    if (sb_q.size() == 0) begin
      $display("[TB] FAIL scoreboard_empty: got 0x%0h, nothing expected", actual);
    end else begin
      e = sb_q.pop_front();
      if (actual === e.value) pass_cnt++;
      else $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", e.name, actual, e.value);
    end
  endtask

  task automatic waitEdges(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic regWrite(input logic [31:0] a, input logic [31:0] d);
    addr = a;
    wd   = d;
    we   = 1'b1;
    @(posedge clk);
    @(negedge clk);
    we = 1'b0;
  endtask

  task automatic readCheck(input string n, input logic [31:0] a, input logic [31:0] e);
    addr = a;
    expectPush(n, e);
    #1;
    checkOutput(rd);
  endtask

  // sel 0 watches pwm_h, sel 1 watches pwm_l; reports clk edges until the level is seen
  task automatic expectCount(input string n, input int sel, input logic val, input int exp_edges);
    int cnt_edges;
    expectPush(n, 32'(exp_edges));
    cnt_edges = -1;
    for (int i = 1; i <= 60; i++) begin
      @(negedge clk);
      if (((sel == 0) ? pwm_h : pwm_l) == val) begin
        cnt_edges = i;
        break;
      end
    end
    checkOutput(32'(cnt_edges));
  endtask

  task automatic expectLevel(input string n, input logic actual, input logic e);
    expectPush(n, {31'b0, e});
    checkOutput({31'b0, actual});
  endtask

  task automatic applyStimulus(input reg_vec_t v);
    if (v.we) regWrite(v.addr, v.wd);
    readCheck(v.name, v.addr, v.exp_rd);
  endtask

  initial begin
    int h_before;
    logic lvl;

    vecs[0] = '{"rd_ctrl_rst",   32'h0, 1'b0, 32'h0,        32'h0};
    vecs[1] = '{"rd_dt_rst",     32'h4, 1'b0, 32'h0,        32'h0};
    vecs[2] = '{"rd_status_rst", 32'h8, 1'b0, 32'h0,        32'h0};
    vecs[3] = '{"rd_reg3_rst",   32'hC, 1'b0, 32'h0,        32'h0};
    vecs[4] = '{"wr_dt_mask",    32'h4, 1'b1, 32'hFFFFFF04, 32'h4};
    vecs[5] = '{"wr_reg3_ign",   32'hC, 1'b1, 32'hFFFFFFFF, 32'h0};
    vecs[6] = '{"wr_ctrl_off",   32'h0, 1'b1, 32'hFFFFFFFE, 32'h0};
    vecs[7] = '{"wr_status_ro",  32'h8, 1'b1, 32'hFFFFFFFF, 32'h0};

    resetn    = 1'b0;
    addr      = '0;
    we        = 1'b0;
    wd        = '0;
    pwm_in    = 1'b0;
    pwm_fault = 1'b0;
    waitEdges(2);
    resetn = 1'b1;
    expectLevel("rst_pwm_h", pwm_h, 1'b0);
    expectLevel("rst_pwm_l", pwm_l, 1'b0);

    for (int i = 0; i < 8; i++) applyStimulus(vecs[i]);

    // dt=4, pwm_in low: 1 edge to enter DEAD, 5 DEAD cycles, then LO
    $display("[TB] enable with dt=4");
    regWrite(32'h0, 32'h1);
    expectCount("first_lo_rise", 1, 1'b1, 6);
    readCheck("status_lo", 32'h8, 32'h3);
    pwm_in = 1'b1;
    expectCount("lo_drop", 1, 1'b0, 3);
    expectCount("hi_rise_dt4", 0, 1'b1, 5);
    readCheck("status_hi", 32'h8, 32'h2);

    $display("[TB] dt=0 square wave");
    regWrite(32'h4, 32'h0);
    for (int p = 0; p < 5; p++) begin
      lvl = (p % 2 == 0) ? 1'b0 : 1'b1;
      pwm_in = lvl;
      expectCount($sformatf("sq_drop_%0d", p), lvl ? 1 : 0, 1'b0, 3);
      expectCount($sformatf("sq_rise_%0d", p), lvl ? 0 : 1, 1'b1, 1);
      waitEdges(6);
    end

    $display("[TB] dt=6 glitch in LO");
    regWrite(32'h4, 32'h6);
    h_before = h_high_cnt;
    pwm_in = 1'b1;
    expectCount("glitch_lo_drop", 1, 1'b0, 3);
    pwm_in = 1'b0;
    expectCount("glitch_lo_back", 1, 1'b1, 10);
    expectPush("glitch_no_hi", 32'h0);
    checkOutput(32'(h_high_cnt - h_before));

    $display("[TB] disable while HI");
    pwm_in = 1'b1;
    expectCount("hi_rise_dt6", 0, 1'b1, 10);
    regWrite(32'h0, 32'h0);
    expectLevel("off_same_cycle_h", pwm_h, 1'b1);
    waitEdges(1);
    expectLevel("off_pwm_h", pwm_h, 1'b0);
    expectLevel("off_pwm_l", pwm_l, 1'b0);
    readCheck("off_status", 32'h8, 32'h0);

    $display("[TB] deadtime rewrite mid-band");
    regWrite(32'h0, 32'h1);
    regWrite(32'h4, 32'd10);
    expectCount("band_old_dt", 0, 1'b1, 7);
    pwm_in = 1'b0;
    expectCount("hi_drop_dt10", 0, 1'b0, 3);
    expectCount("band_new_dt", 1, 1'b1, 11);
    pwm_in = 1'b1;
    expectCount("lo_drop_dt10", 1, 1'b0, 3);
    expectCount("hi_rise_dt10", 0, 1'b1, 11);

    $display("[TB] async reset mid-HI");
    waitEdges(2);
    #2;
    resetn = 1'b0;
    #1;
    expectLevel("async_rst_h", pwm_h, 1'b0);
    expectLevel("async_rst_l", pwm_l, 1'b0);
    readCheck("rst_ctrl", 32'h0, 32'h0);
    readCheck("rst_dt", 32'h4, 32'h0);
    readCheck("rst_status", 32'h8, 32'h0);
    @(negedge clk);
    pwm_in = 1'b0;
    resetn = 1'b1;

`ifdef NF_PWM_DT_FAULT_EN
    $display("[TB] fault sequence");
    pwm_in = 1'b1;
    regWrite(32'h4, 32'h2);
    regWrite(32'h0, 32'h1);
    expectCount("fault_pre_hi", 0, 1'b1, 4);
    pwm_fault = 1'b1;
    expectCount("fault_hi_drop", 0, 1'b0, 3);
    readCheck("fault_status", 32'h8, 32'h8);
    regWrite(32'h8, 32'h8);
    readCheck("fault_w1c_refused", 32'h8, 32'h8);
    pwm_fault = 1'b0;
    waitEdges(3);
    readCheck("fault_held_idle", 32'h8, 32'h8);
    regWrite(32'h8, 32'h8);
    readCheck("fault_cleared", 32'h8, 32'h0);
    waitEdges(1);
    readCheck("fault_resume_dead", 32'h8, 32'h1);
    expectCount("fault_resume_hi", 0, 1'b1, 3);
`endif

    expectPush("no_overlap", 32'h0);
    checkOutput(32'(overlap_cnt));

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
